psum_accum: RTL and testbench

Sequential partial-sum accumulator that sits directly downstream of the combinational `mac` and closes its psum loop. Each beat, it drives the MAC's `i_psum` from a local 24-bit register and captures the MAC's `o_result`. After the configured number of beats, it:
- restores the VSQ 8-bit scale (the deferred `<< 8`),
- widens the result to 32 bits,
- requantises it to INT8 for the next layer.

The final result goes out through a one-slot valid/ready output register.

---
 rtl/psum_accum_pkg.sv | 26 ++
 rtl/psum_accum_requant.sv | 31 +++
 rtl/psum_accum.sv | 136 +++++++++++++
 tb/tb_psum_accum.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/psum_accum_pkg.sv
// Shared types for the psum accumulator: mode codes, FSM states and the
// scale-restore helper applied to the last MAC result of a group.
package psum_accum_pkg;

  localparam int unsigned PSUM_W = 24;
  localparam int unsigned ACC_W  = 32;

  typedef enum logic [1:0] {
    MODE_INT8     = 2'd0,
    MODE_INT4     = 2'd1,
    MODE_INT4_VSQ = 2'd2
  } mode_e;

  typedef enum logic {
    ACC_IDLE  = 1'b0,
    ACC_ACCUM = 1'b1
  } state_e;

  // VSQ groups carry the deferred << 8 scale; other modes just sign-extend.
  function automatic logic [ACC_W-1:0] restore_scale(input mode_e m,
                                                     input logic [PSUM_W-1:0] r);
    if (m == MODE_INT4_VSQ) return {r, 8'b0};
    return {{(ACC_W-PSUM_W){r[PSUM_W-1]}}, r};
  endfunction

endpackage

// File: rtl/psum_accum_requant.sv
// Combinational INT8 requantiser: round-half-up arithmetic right shift of a
// 32-bit accumulation, clamped to the signed 8-bit range.
module requant_s8 (
  input  logic [31:0] acc_i,
  input  logic [4:0]  shift_i,
  output logic [7:0]  q_o,
  output logic        sat_o
);

  logic signed [32:0] rnd;
  logic signed [32:0] sum;
  logic signed [32:0] shr;

  always_comb begin
    rnd = '0;
    if (shift_i != 5'd0) rnd[shift_i - 5'd1] = 1'b1;
    // 33 bits keep the rounding add from overflowing at the top of the range.
    sum   = $signed({acc_i[31], acc_i}) + rnd;
    shr   = sum >>> shift_i;
    q_o   = shr[7:0];
    sat_o = 1'b0;
    if (shr > 33'sd127) begin
      q_o   = 8'h7f;
      sat_o = 1'b1;
    end else if (shr < -33'sd128) begin
      q_o   = 8'h80;
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulator closing the MAC psum loop: feeds o_psum back, counts
// beats per group and pushes the scaled, requantised result into a 1-slot output.
module psum_accum
  import psum_accum_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_mode,
  input  logic [LEN_W-1:0] i_len,
  input  logic [4:0]       i_shift,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [23:0]      i_result,
  output logic [23:0]      o_psum,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_acc,
  output logic [7:0]       o_q,
  output logic             o_sat,
  output logic             o_busy
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
  mode_e            mode_q, mode_d;
  logic [4:0]       shift_q, shift_d;
  logic [23:0]      psum_q, psum_d;
  logic             valid_q, valid_d;
  logic [31:0]      acc_q, acc_d;
  logic [7:0]       q_q, q_d;
  logic             sat_q, sat_d;

  logic [LEN_W-1:0] eff_len, cnt_inc;
  mode_e            cur_mode;
  logic [4:0]       cur_shift;
  logic             last, accept;
  logic [31:0]      fin_acc;
  logic [7:0]       fin_q;
  logic             fin_sat;

  assign fin_acc = restore_scale(cur_mode, i_result);

  requant_s8 u_requant (
    .acc_i   (fin_acc),
    .shift_i (cur_shift),
    .q_o     (fin_q),
    .sat_o   (fin_sat)
  );

  always_comb begin
    eff_len = (i_len == '0) ? LEN_W'(1) : i_len;
    cnt_inc = cnt_q + LEN_W'(1);
    // On a first beat the live config applies; afterwards only the latched copy.
    if (state_q == ACC_IDLE) begin
      cur_mode  = mode_e'(i_mode);
      cur_shift = i_shift;
      last      = (eff_len == LEN_W'(1));
    end else begin
      cur_mode  = mode_q;
      cur_shift = shift_q;
      last      = (cnt_inc == len_q);
    end
    o_ready = ((state_q == ACC_ACCUM) && !last) || !valid_q || i_ready;
    accept  = i_valid && o_ready;

    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    shift_d = shift_q;
    psum_d  = psum_q;
    valid_d = valid_q;
    acc_d   = acc_q;
    q_d     = q_q;
    sat_d   = sat_q;

    if (accept) begin
      psum_d = i_result;
      if (state_q == ACC_IDLE) begin
        mode_d  = cur_mode;
        len_d   = eff_len;
        shift_d = i_shift;
        cnt_d   = LEN_W'(1);
      end else begin
        cnt_d = cnt_inc;
      end
      state_d = last ? ACC_IDLE : ACC_ACCUM;
    end

    // A push on the last beat wins over a simultaneous pop, so the slot stays full.
    if (accept && last) begin
      valid_d = 1'b1;
      acc_d   = fin_acc;
      q_d     = fin_q;
      sat_d   = fin_sat;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ACC_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= MODE_INT8;
      shift_q <= '0;
      psum_q  <= '0;
      valid_q <= 1'b0;
      acc_q   <= '0;
      q_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      shift_q <= shift_d;
      psum_q  <= psum_d;
      valid_q <= valid_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      sat_q   <= sat_d;
    end
  end

  assign o_psum  = (state_q == ACC_ACCUM) ? psum_q : '0;
  assign o_busy  = (state_q == ACC_ACCUM);
  assign o_valid = valid_q;
  assign o_acc   = acc_q;
  assign o_q     = q_q;
  assign o_sat   = sat_q;

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum; the MAC is modelled as i_result = psum + product.
module tb_psum_accum;
  import psum_accum_pkg::*;

  logic        clk;
  logic        i_rst_n;
  logic [1:0]  i_mode;
  logic [7:0]  i_len;
  logic [4:0]  i_shift;
  logic        i_valid;
  logic        o_ready;
  logic [23:0] i_result;
  logic [23:0] o_psum;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_acc;
  logic [7:0]  o_q;
  logic        o_sat;
  logic        o_busy;

  int n_asserts = 0;
  int n_fail    = 0;

  psum_accum #(.LEN_W(8)) dut (
    .i_clk    (clk),
    .i_rst_n  (i_rst_n),
    .i_mode   (i_mode),
    .i_len    (i_len),
    .i_shift  (i_shift),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_result (i_result),
    .o_psum   (o_psum),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_acc    (o_acc),
    .o_q      (o_q),
    .o_sat    (o_sat),
    .o_busy   (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [7:0] len,
                       input logic [4:0] sh, input logic [23:0] res);
    i_valid  = 1'b1;
    i_mode   = m;
    i_len    = len;
    i_shift  = sh;
    i_result = res;
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_mode = '0; i_len = '0;
    i_shift = '0;   i_result = '0;  i_ready = 1'b1;
    #7;
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_acc",   o_acc, 32'd0);
    chk("rst_q",     {24'b0, o_q}, 32'd0);
    chk("rst_sat",   {31'b0, o_sat}, 32'd0);
    chk("rst_busy",  {31'b0, o_busy}, 32'd0);
    chk("rst_ready", {31'b0, o_ready}, 32'd1);
    chk("rst_psum",  {8'b0, o_psum}, 32'd0);
    @(negedge clk); i_rst_n = 1'b1;

    // INT8 len=3: products 100, 150, -20, shift 0
    drive(MODE_INT8, 8'd3, 5'd0, 24'd100);
    #1 chk("t1_psum0", {8'b0, o_psum}, 32'd0);
    chk("t1_ready0", {31'b0, o_ready}, 32'd1);
    @(negedge clk);
    chk("t1_busy", {31'b0, o_busy}, 32'd1);
    drive(MODE_INT8, 8'd3, 5'd0, 24'd250);
    #1 chk("t1_psum1", {8'b0, o_psum}, 32'd100);
    @(negedge clk);
    chk("t1_valid_early", {31'b0, o_valid}, 32'd0);
    drive(MODE_INT8, 8'd3, 5'd0, 24'd230);
    #1 chk("t1_psum2", {8'b0, o_psum}, 32'd250);
    @(negedge clk);
    chk("t1_valid", {31'b0, o_valid}, 32'd1);
    chk("t1_acc",   o_acc, 32'd230);
    chk("t1_q",     {24'b0, o_q}, 32'h7f);
    chk("t1_sat",   {31'b0, o_sat}, 32'd1);
    chk("t1_idle",  {31'b0, o_busy}, 32'd0);

    // VSQ len=1, product -3, shift 4
    drive(MODE_INT4_VSQ, 8'd1, 5'd4, 24'hFFFFFD);
    @(negedge clk);
    chk("t2_valid", {31'b0, o_valid}, 32'd1);
    chk("t2_acc",   o_acc, 32'hFFFFFD00);
    chk("t2_q",     {24'b0, o_q}, 32'hD0);
    chk("t2_sat",   {31'b0, o_sat}, 32'd0);

    // Back-pressure: INT8 len=3 (10,20,30) through i_ready=0, then a stalled len=1 group
    drive(MODE_INT8, 8'd3, 5'd0, 24'd10);
    #1 chk("t3_ready_b1", {31'b0, o_ready}, 32'd1);
    @(negedge clk);
    chk("t3_popped", {31'b0, o_valid}, 32'd0);
    i_ready = 1'b0;
    drive(MODE_INT8, 8'd3, 5'd0, 24'd30);
    #1 chk("t3_psum1", {8'b0, o_psum}, 32'd10);
    chk("t3_ready_b2", {31'b0, o_ready}, 32'd1);
    @(negedge clk);
    drive(MODE_INT8, 8'd3, 5'd0, 24'd60);
    #1 chk("t3_psum2", {8'b0, o_psum}, 32'd30);
    chk("t3_ready_b3", {31'b0, o_ready}, 32'd1);
    @(negedge clk);
    chk("t3_valid", {31'b0, o_valid}, 32'd1);
    chk("t3_acc",   o_acc, 32'd60);
    drive(MODE_INT4, 8'd1, 5'd2, 24'hFFFC18);
    #1 chk("t3_stall", {31'b0, o_ready}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t3_hold_valid", {31'b0, o_valid}, 32'd1);
      chk("t3_hold_acc",   o_acc, 32'd60);
      chk("t3_hold_q",     {24'b0, o_q}, 32'h3C);
      chk("t3_hold_sat",   {31'b0, o_sat}, 32'd0);
      chk("t3_hold_ready", {31'b0, o_ready}, 32'd0);
    end
    i_ready = 1'b1;
    #1 chk("t3_ready_rise", {31'b0, o_ready}, 32'd1);
    @(negedge clk);
    chk("t3_pp_valid", {31'b0, o_valid}, 32'd1);
    chk("t3_pp_acc",   o_acc, 32'hFFFFFC18);
    chk("t3_pp_q",     {24'b0, o_q}, 32'h80);
    chk("t3_pp_sat",   {31'b0, o_sat}, 32'd1);

    // Back-to-back len=1 INT4 groups, products 3*k
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin
        chk("t4_valid", {31'b0, o_valid}, 32'd1);
        chk("t4_acc",   o_acc, 32'(3 * (k - 1)));
      end
      drive(MODE_INT4, 8'd1, 5'd0, 24'(3 * k));
      #1 chk("t4_psum", {8'b0, o_psum}, 32'd0);
      chk("t4_ready", {31'b0, o_ready}, 32'd1);
      @(negedge clk);
    end
    chk("t4_last_acc", o_acc, 32'd24);

    // len=0 behaves as one beat
    drive(MODE_INT8, 8'd0, 5'd0, 24'd5);
    @(negedge clk);
    chk("t5_valid", {31'b0, o_valid}, 32'd1);
    chk("t5_acc",   o_acc, 32'd5);
    chk("t5_busy",  {31'b0, o_busy}, 32'd0);

    // Config changes mid-group are ignored: VSQ len=2 shift 8 stays latched
    drive(MODE_INT4_VSQ, 8'd2, 5'd8, 24'd1);
    #1 chk("t6_psum0", {8'b0, o_psum}, 32'd0);
    @(negedge clk);
    drive(MODE_INT8, 8'd5, 5'd0, 24'd3);
    #1 chk("t6_psum1", {8'b0, o_psum}, 32'd1);
    chk("t6_ready", {31'b0, o_ready}, 32'd1);
    @(negedge clk);
    chk("t6_busy",  {31'b0, o_busy}, 32'd0);
    chk("t6_valid", {31'b0, o_valid}, 32'd1);
    chk("t6_acc",   o_acc, 32'h300);
    chk("t6_q",     {24'b0, o_q}, 32'h03);
    chk("t6_sat",   {31'b0, o_sat}, 32'd0);

    // Reset asserted during beat 2 of a len=4 group
    drive(MODE_INT8, 8'd4, 5'd0, 24'd7);
    @(negedge clk);
    drive(MODE_INT8, 8'd4, 5'd0, 24'd15);
    #1 chk("t7_psum1", {8'b0, o_psum}, 32'd7);
    #1 i_rst_n = 1'b0;
    #1;
    chk("t7_busy",  {31'b0, o_busy}, 32'd0);
    chk("t7_psum",  {8'b0, o_psum}, 32'd0);
    chk("t7_valid", {31'b0, o_valid}, 32'd0);
    chk("t7_acc",   o_acc, 32'd0);
    chk("t7_q",     {24'b0, o_q}, 32'd0);
    chk("t7_sat",   {31'b0, o_sat}, 32'd0);
    i_valid = 1'b0;
    @(negedge clk); i_rst_n = 1'b1;
    drive(MODE_INT8, 8'd1, 5'd0, 24'd9);
    #1 chk("t7_new_psum", {8'b0, o_psum}, 32'd0);
    @(negedge clk);
    chk("t7_new_valid", {31'b0, o_valid}, 32'd1);
    chk("t7_new_acc",   o_acc, 32'd9);
    i_valid = 1'b0;
    @(negedge clk);
    chk("t7_drained", {31'b0, o_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
